triangle_checker: RTL and testbench



---
 rtl/triangle_pkg.sv | 7 +
 rtl/triangle_checker_if.sv | 18 +
 rtl/sat_counter.sv | 14 +
 rtl/triangle_checker.sv | 56 +++++
 tb/tb_triangle_checker.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/triangle_pkg.sv
// triangle_pkg: shared state and direction encodings for the triangle source and checker.
// No ports; provides checker_state_t and the DIR_UP / DIR_DOWN direction constants.
package triangle_pkg;
    typedef enum logic [1:0] {ACQUIRE, SYNC, LOCKED_UP, LOCKED_DOWN} checker_state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/triangle_checker_if.sv
// triangle_checker_if: sample stream into the checker and its monitor outputs.
// master: drives ena/in/clear_counts, observes status; slave: the checker side.
interface triangle_checker_if #(parameter int N = 8, parameter int PERIOD_W = 16, parameter int ERR_W = 8);
    logic                ena;
    logic [N-1:0]        in;
    logic                clear_counts;
    logic                locked;
    logic                direction;
    logic                peak;
    logic                trough;
    logic                error;
    logic [PERIOD_W-1:0] period_count;
    logic [ERR_W-1:0]    error_count;
    modport master (output ena, in, clear_counts,
                    input locked, direction, peak, trough, error, period_count, error_count);
    modport slave (input ena, in, clear_counts,
                   output locked, direction, peak, trough, error, period_count, error_count);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; clr beats inc.
// Ports: clk, rst (async active-low), inc, clr (sync), count.
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/triangle_checker.sv
// triangle_checker: locks onto a 0..MAX..0 triangle stream and flags peaks, troughs and errors.
// Ports: clk, rst (async active-low), bus (slave): ena/in/clear_counts in; locked, direction,
// peak, trough, error, period_count, error_count out (all registered).
module triangle_checker import triangle_pkg::*; #(
    parameter int N = 8,
    parameter int PERIOD_W = 16,
    parameter int ERR_W = 8
) (
    input logic               clk,
    input logic               rst,
    triangle_checker_if.slave bus
);
    localparam logic [N-1:0] MAX = '1;
    checker_state_t state, state_n;
    logic [N-1:0] prev;
    logic up_ok, dn_ok, go_up, go_dn, peak_n, trough_n, err_n, locked_n;
    // Wrap is never a legal step, hence the guards on prev at the extremes.
    always_comb begin
        up_ok = bus.in == prev + N'(1) && prev != MAX;
        dn_ok = bus.in == prev - N'(1) && prev != '0;
        go_up = bus.ena && (state == SYNC || state == LOCKED_UP) && up_ok;
        go_dn = bus.ena && ((state == SYNC && !up_ok) || state == LOCKED_DOWN) && dn_ok;
        peak_n = go_up && bus.in == MAX;
        trough_n = go_dn && bus.in == '0;
        err_n = bus.ena && ((state == LOCKED_UP && !up_ok) || (state == LOCKED_DOWN && !dn_ok));
        // Turnaround applies even on the locking sample, so a lock straight onto an extreme flips direction.
        state_n = !bus.ena ? state :
                  go_up ? (peak_n ? LOCKED_DOWN : LOCKED_UP) :
                  go_dn ? (trough_n ? LOCKED_UP : LOCKED_DOWN) : SYNC;
        locked_n = state_n == LOCKED_UP || state_n == LOCKED_DOWN;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= ACQUIRE;
            prev <= '0;
            bus.locked <= 1'b0;
            bus.direction <= DIR_UP;
            bus.peak <= 1'b0;
            bus.trough <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.ena) prev <= bus.in;
            bus.locked <= locked_n;
            if (locked_n) bus.direction <= state_n == LOCKED_UP ? DIR_UP : DIR_DOWN;
            bus.peak <= peak_n;
            bus.trough <= trough_n;
            bus.error <= err_n;
        end
    sat_counter #(.W(PERIOD_W)) u_period (
        .clk(clk), .rst(rst), .inc(trough_n), .clr(bus.clear_counts), .count(bus.period_count)
    );
    sat_counter #(.W(ERR_W)) u_error (
        .clk(clk), .rst(rst), .inc(err_n), .clr(bus.clear_counts), .count(bus.error_count)
    );
endmodule

// File: tb/tb_triangle_checker.sv
// tb_triangle_checker: directed checks of triangle_checker with N=4, ERR_W=2.
module tb_triangle_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    triangle_checker_if #(.N(4), .PERIOD_W(16), .ERR_W(2)) bus ();
    triangle_checker #(.N(4), .PERIOD_W(16), .ERR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [3:0] v, input logic clr = 1'b0);
        bus.ena = 1'b1;
        bus.in = v;
        bus.clear_counts = clr;
        @(posedge clk);
        #1;
        bus.ena = 1'b0;
        bus.clear_counts = 1'b0;
    endtask
    task automatic idle();
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask
    task automatic chk_flags(input string tag, input logic l, input logic d, input logic p, input logic t, input logic e);
        chk({tag, "_locked"}, bus.locked, l);
        chk({tag, "_dir"}, bus.direction, d);
        chk({tag, "_peak"}, bus.peak, p);
        chk({tag, "_trough"}, bus.trough, t);
        chk({tag, "_error"}, bus.error, e);
    endtask
    initial begin
        int m;
        bus.ena = 1'b0;
        bus.in = '0;
        bus.clear_counts = 1'b0;
        @(posedge clk);
        #1;
        chk_flags("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_period", bus.period_count, 0);
        chk("reset_errcnt", bus.error_count, 0);
        rst = 1'b1;
        // Clean stream: 0,1..15,14..0 repeated, three full periods.
        for (int k = 0; k <= 90; k++) begin
            m = k % 30;
            send(4'(m <= 15 ? m : 30 - m));
            chk("clean_locked", bus.locked, k >= 1);
            if (k >= 1) chk("clean_dir", bus.direction, (m >= 15) ? 0 : 1);
            chk("clean_peak", bus.peak, m == 15);
            chk("clean_trough", bus.trough, k >= 30 && m == 0);
            chk("clean_error", bus.error, 0);
        end
        chk("clean_period", bus.period_count, 3);
        chk("clean_errcnt", bus.error_count, 0);
        // Acquire mid-descent.
        do_reset();
        send(4'd9);
        chk("desc_9_locked", bus.locked, 0);
        send(4'd8);
        chk_flags("desc_8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int v = 7; v >= 1; v--) send(4'(v));
        chk_flags("desc_1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(4'd0);
        chk_flags("desc_0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("desc_period", bus.period_count, 1);
        send(4'd1);
        chk_flags("desc_up1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Error injection: 5,6,7,9,10,11.
        do_reset();
        send(4'd5);
        send(4'd6);
        chk_flags("inj_6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(4'd7);
        send(4'd9);
        chk_flags("inj_9", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("inj_9_errcnt", bus.error_count, 1);
        send(4'd10);
        chk_flags("inj_10", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(4'd11);
        chk_flags("inj_11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("inj_11_errcnt", bus.error_count, 1);
        // ena gaps around the peak.
        send(4'd12);
        send(4'd13);
        send(4'd14);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_flags("gap_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        send(4'd15);
        chk_flags("gap_15", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_flags("gap_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(4'd14);
        chk_flags("gap_14", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_errcnt", bus.error_count, 1);
        // Saturation of the 2-bit error counter: five mismatches.
        do_reset();
        send(4'd0);
        send(4'd1);
        send(4'd5);
        chk("sat_e1", bus.error_count, 1);
        send(4'd6);
        send(4'd9);
        chk("sat_e2", bus.error_count, 2);
        send(4'd10);
        send(4'd3);
        chk("sat_e3", bus.error_count, 3);
        send(4'd4);
        send(4'd12);
        chk("sat_e4", bus.error_count, 3);
        chk("sat_e4_pulse", bus.error, 1);
        send(4'd13);
        send(4'd1);
        chk("sat_e5", bus.error_count, 3);
        send(4'd2);
        send(4'd7, 1'b1);
        chk("clr_pulse", bus.error, 1);
        chk("clr_errcnt", bus.error_count, 0);
        // Build nonzero state, locked down, then reset asynchronously.
        send(4'd8);
        send(4'd3);
        chk("pre_rst_errcnt", bus.error_count, 1);
        send(4'd2);
        chk_flags("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk_flags("async_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("async_rst_errcnt", bus.error_count, 0);
        chk("async_rst_period", bus.period_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(4'd5);
        chk("reacq_1", bus.locked, 0);
        send(4'd6);
        chk_flags("reacq_2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
